wired_dispatch: RTL and testbench

- In-order, 2-wide dispatch stage directly downstream of the frontend packet FIFO.
- Accepts dual-instruction packets (pipeline_ctrl_pack_t[1:0] plus mask) from the frontend.
- Holds each packet in one register stage and checks operands against a 32-entry busy-register scoreboard.
- Issues the oldest ready instructions in program order to the backend, and splits a packet when only its older half can go.

---
 rtl/wired_dispatch_pkg.sv | 20 ++
 rtl/wired_scoreboard.sv | 39 +++
 rtl/wired_dispatch.sv | 100 ++++++++++
 tb/tb_wired_dispatch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wired_dispatch_pkg.sv
// wired_dispatch_pkg: shared pipeline types and constants for the dispatch stage.
`ifndef _WIRED_NUM_ARCH_REG
`define _WIRED_NUM_ARCH_REG 32
`endif
package wired_dispatch_pkg;
    localparam int NUM_ARCH_REG = `_WIRED_NUM_ARCH_REG;

    typedef struct packed {
        logic [1:0][4:0] r_reg;
        logic [4:0]      w_reg;
    } reg_info_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  op;
        reg_info_t   ri;
    } pipeline_ctrl_pack_t;

    typedef logic [NUM_ARCH_REG-1:0] dispatch_busy_t;
endpackage

// File: rtl/wired_scoreboard.sv
// wired_scoreboard: busy bit per architectural register with writeback bypass on queries.
module wired_scoreboard
    import wired_dispatch_pkg::*;
#(
    parameter int NUM_WB = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             set_valid_i,
    input  logic [1:0][4:0]        set_reg_i,
    input  logic [NUM_WB-1:0]      clr_valid_i,
    input  logic [NUM_WB-1:0][4:0] clr_reg_i,
    input  logic [3:0][4:0]        rd_reg_i,
    input  logic [1:0][4:0]        wr_reg_i,
    output logic [3:0]             rd_ready_o,
    output logic [1:0]             wr_ready_o
);
    dispatch_busy_t busy_q, busy_d, set_m, clr_m, eff;

    always_comb begin
        set_m = '0;
        clr_m = '0;
        for (int i = 0; i < 2; i++)
            if (set_valid_i[i]) set_m[set_reg_i[i]] = 1'b1;
        for (int i = 0; i < NUM_WB; i++)
            if (clr_valid_i[i]) clr_m[clr_reg_i[i]] = 1'b1;
        set_m[0] = 1'b0;
        eff = busy_q & ~clr_m;
        busy_d = eff | set_m;
        for (int i = 0; i < 4; i++)
            rd_ready_o[i] = (rd_reg_i[i] == 5'd0) | !eff[rd_reg_i[i]];
        for (int i = 0; i < 2; i++)
            wr_ready_o[i] = (wr_reg_i[i] == 5'd0) | !eff[wr_reg_i[i]];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
endmodule

// File: rtl/wired_dispatch.sv
// wired_dispatch: 2-wide in-order dispatch; holds one packet and issues the oldest ready
// instructions, splitting a packet when only its older half can go.
module wired_dispatch
    import wired_dispatch_pkg::*;
#(
    parameter int NUM_WB = 2,
    parameter int PERF_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     pkg_valid_i,
    output logic                     pkg_ready_o,
    input  logic [1:0]               pkg_mask_i,
    input  pipeline_ctrl_pack_t [1:0] pkg_i,
    output logic                     iss_valid_o,
    input  logic                     iss_ready_i,
    output logic [1:0]               iss_mask_o,
    output pipeline_ctrl_pack_t [1:0] iss_o,
    input  logic [NUM_WB-1:0]        wb_valid_i,
    input  logic [NUM_WB-1:0][4:0]   wb_reg_i,
    output logic [PERF_W-1:0]        perf_stall_o
);
    logic                      held_valid_q, held_valid_d;
    logic [1:0]                held_mask_q, held_mask_d;
    pipeline_ctrl_pack_t [1:0] held_p_q, held_p_d;
    logic [PERF_W-1:0]         perf_q, perf_d;
    logic [3:0]                rd_ready;
    logic [1:0]                wr_ready, set_valid;
    logic [4:0]                w0, w1;
    logic                      hz, off0, off1, fire, all_off, load;

    assign w0 = held_p_q[0].ri.w_reg;
    assign w1 = held_p_q[1].ri.w_reg;

    wired_scoreboard #(.NUM_WB(NUM_WB)) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_valid_i (set_valid),
        .set_reg_i   ({w1, w0}),
        .clr_valid_i (wb_valid_i),
        .clr_reg_i   (wb_reg_i),
        .rd_reg_i    ({held_p_q[1].ri.r_reg[1], held_p_q[1].ri.r_reg[0],
                       held_p_q[0].ri.r_reg[1], held_p_q[0].ri.r_reg[0]}),
        .wr_reg_i    ({w1, w0}),
        .rd_ready_o  (rd_ready),
        .wr_ready_o  (wr_ready)
    );

    // lane1 must not read or rewrite what lane0 writes in the same issue group
    assign hz = (w0 != 5'd0) & ((held_p_q[1].ri.r_reg[0] == w0) |
                                (held_p_q[1].ri.r_reg[1] == w0) | (w1 == w0));

    always_comb begin
        off0         = held_valid_q & held_mask_q[0] & (&rd_ready[1:0]) & wr_ready[0];
        off1         = off0 & held_mask_q[1] & (&rd_ready[3:2]) & wr_ready[1] & !hz;
        iss_mask_o   = {off1, off0};
        iss_valid_o  = |iss_mask_o;
        iss_o        = held_p_q;
        fire         = iss_valid_o & iss_ready_i;
        all_off      = iss_mask_o == held_mask_q;
        set_valid    = fire ? iss_mask_o : 2'b00;
        pkg_ready_o  = !held_valid_q | (fire & all_off);
        load         = pkg_valid_i & pkg_ready_o & !flush_i;
        perf_d       = (held_valid_q & !fire & !flush_i & ~&perf_q) ? perf_q + 1'b1 : perf_q;
        perf_stall_o = perf_q;
    end

    always_comb begin
        held_valid_d = held_valid_q;
        held_mask_d  = held_mask_q;
        held_p_d     = held_p_q;
        if (flush_i) begin
            held_valid_d = 1'b0;
        end else if (load) begin
            held_valid_d = |pkg_mask_i;
            held_mask_d  = (pkg_mask_i == 2'b10) ? 2'b01 : pkg_mask_i;
            held_p_d[0]  = (pkg_mask_i == 2'b10) ? pkg_i[1] : pkg_i[0];
            held_p_d[1]  = pkg_i[1];
        end else if (fire & all_off) begin
            held_valid_d = 1'b0;
        end else if (fire) begin
            held_mask_d  = 2'b01;
            held_p_d[0]  = held_p_q[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            held_valid_q <= 1'b0;
            held_mask_q  <= 2'b00;
            held_p_q     <= '0;
            perf_q       <= '0;
        end else begin
            held_valid_q <= held_valid_d;
            held_mask_q  <= held_mask_d;
            held_p_q     <= held_p_d;
            perf_q       <= perf_d;
        end
endmodule

// File: tb/tb_wired_dispatch.sv
// tb_wired_dispatch: table vectors plus hand sequences; an in-order queue checks issued pcs.
module tb_wired_dispatch;
    import wired_dispatch_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      flush_i = 1'b0;
    logic                      pkg_valid_i = 1'b0;
    logic                      pkg_ready_o;
    logic [1:0]                pkg_mask_i = 2'b00;
    pipeline_ctrl_pack_t [1:0] pkg_i = '0;
    logic                      iss_valid_o;
    logic                      iss_ready_i = 1'b1;
    logic [1:0]                iss_mask_o;
    pipeline_ctrl_pack_t [1:0] iss_o;
    logic [1:0]                wb_valid_i = 2'b00;
    logic [1:0][4:0]           wb_reg_i = '0;
    logic [3:0]                perf_stall_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] expq[$];

    always #5 clk = ~clk;

    wired_dispatch #(.NUM_WB(2), .PERF_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .pkg_valid_i  (pkg_valid_i),
        .pkg_ready_o  (pkg_ready_o),
        .pkg_mask_i   (pkg_mask_i),
        .pkg_i        (pkg_i),
        .iss_valid_o  (iss_valid_o),
        .iss_ready_i  (iss_ready_i),
        .iss_mask_o   (iss_mask_o),
        .iss_o        (iss_o),
        .wb_valid_i   (wb_valid_i),
        .wb_reg_i     (wb_reg_i),
        .perf_stall_o (perf_stall_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic pipeline_ctrl_pack_t mk(input logic [31:0] pc, input logic [4:0] w,
                                               input logic [4:0] a, input logic [4:0] b);
        mk = '0;
        mk.pc = pc;
        mk.ri.w_reg = w;
        mk.ri.r_reg[0] = a;
        mk.ri.r_reg[1] = b;
    endfunction

    // Scoreboard: program-order pcs pushed on accept, popped lane by lane on fire
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
        end else begin
            if (iss_valid_o && iss_ready_i)
                for (int l = 0; l < 2; l++)
                    if (iss_mask_o[l]) begin
                        if (expq.size() == 0) chk("issue_unexpected", iss_o[l].pc, 32'hFFFF_FFFF);
                        else chk("issue_pc", iss_o[l].pc, expq.pop_front());
                    end
            if (flush_i) expq.delete();
            if (pkg_valid_i && pkg_ready_o && !flush_i)
                for (int l = 0; l < 2; l++)
                    if (pkg_mask_i[l]) expq.push_back(pkg_i[l].pc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] m, input pipeline_ctrl_pack_t p0, input pipeline_ctrl_pack_t p1);
        pkg_valid_i = 1'b1;
        pkg_mask_i = m;
        pkg_i[0] = p0;
        pkg_i[1] = p1;
        tick();
        pkg_valid_i = 1'b0;
        #1;
    endtask

    task automatic clean();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int r = 1; r < 32; r += 2) begin
            wb_valid_i = 2'b11;
            wb_reg_i[0] = 5'(r);
            wb_reg_i[1] = 5'(r + 1);
            tick();
        end
        wb_valid_i = 2'b00;
        #1;
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [4:0]  w0, a0, b0, w1, a1, b1;
        logic [1:0]  e1, e2;
        logic [31:0] eb;
    } vec_t;

    vec_t tv[8];
    pipeline_ctrl_pack_t [1:0] saved;

    initial begin
        tv[0] = '{2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 2'b11, 2'b00, 32'h0000_0012};
        tv[1] = '{2'b11, 5'd7, 5'd1, 5'd2, 5'd8, 5'd7, 5'd0, 2'b01, 2'b00, 32'h0000_0080};
        tv[2] = '{2'b10, 5'd0, 5'd0, 5'd0, 5'd5, 5'd1, 5'd2, 2'b01, 2'b00, 32'h0000_0020};
        tv[3] = '{2'b00, 5'd1, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 2'b00, 2'b00, 32'h0000_0000};
        tv[4] = '{2'b01, 5'd0, 5'd3, 5'd0, 5'd6, 5'd0, 5'd0, 2'b01, 2'b00, 32'h0000_0000};
        tv[5] = '{2'b11, 5'd3, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 2'b01, 2'b00, 32'h0000_0008};
        tv[6] = '{2'b11, 5'd2, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 2'b01, 2'b00, 32'h0000_0004};
        tv[7] = '{2'b11, 5'd0, 5'd9, 5'd9, 5'd0, 5'd9, 5'd9, 2'b11, 2'b00, 32'h0000_0000};

        #12;
        chk("rst_iss_valid", 32'(iss_valid_o), 0);
        chk("rst_iss_mask", 32'(iss_mask_o), 0);
        chk("rst_pkg_ready", 32'(pkg_ready_o), 1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_perf", 32'(perf_stall_o), 0);
        chk("rst_busy", dut.u_sb.busy_q, 0);

        for (int v = 0; v < 8; v++) begin
            clean();
            iss_ready_i = 1'b1;
            load(tv[v].m, mk(32'(100 + 2 * v), tv[v].w0, tv[v].a0, tv[v].b0),
                 mk(32'(101 + 2 * v), tv[v].w1, tv[v].a1, tv[v].b1));
            chk($sformatf("v%0d_mask1", v), 32'(iss_mask_o), 32'(tv[v].e1));
            tick();
            chk($sformatf("v%0d_mask2", v), 32'(iss_mask_o), 32'(tv[v].e2));
            chk($sformatf("v%0d_busy", v), dut.u_sb.busy_q, tv[v].eb);
        end

        // Intra-packet RAW: r8 waits in slot0 until r7 writes back
        clean();
        load(2'b11, mk(200, 5'd7, 5'd1, 5'd2), mk(201, 5'd8, 5'd7, 5'd0));
        chk("raw_mask1", 32'(iss_mask_o), 32'b01);
        chk("raw_ready1", 32'(pkg_ready_o), 0);
        tick();
        chk("raw_mask2", 32'(iss_mask_o), 0);
        chk("raw_ready2", 32'(pkg_ready_o), 0);
        chk("raw_slot0_pc", iss_o[0].pc, 201);
        tick();
        chk("raw_mask3", 32'(iss_mask_o), 0);
        wb_valid_i = 2'b01;
        wb_reg_i[0] = 5'd7;
        #1;
        chk("raw_wb_mask", 32'(iss_mask_o), 32'b01);
        chk("raw_wb_ready", 32'(pkg_ready_o), 1);
        tick();
        wb_valid_i = 2'b00;
        #1;
        chk("raw_busy", dut.u_sb.busy_q, 32'h0000_0100);

        // Writeback bypass on a busy source, then a reader that also writes the same reg
        clean();
        load(2'b01, mk(300, 5'd9, 5'd0, 5'd0), '0);
        tick();
        load(2'b01, mk(301, 5'd10, 5'd9, 5'd0), '0);
        chk("byp_stall", 32'(iss_mask_o), 0);
        wb_valid_i = 2'b10;
        wb_reg_i[1] = 5'd9;
        #1;
        chk("byp_mask", 32'(iss_mask_o), 32'b01);
        tick();
        wb_valid_i = 2'b00;
        #1;
        chk("byp_busy", dut.u_sb.busy_q, 32'h0000_0400);
        clean();
        load(2'b01, mk(302, 5'd9, 5'd0, 5'd0), '0);
        tick();
        load(2'b01, mk(303, 5'd9, 5'd9, 5'd0), '0);
        wb_valid_i = 2'b10;
        wb_reg_i[1] = 5'd9;
        #1;
        chk("byp_waw_mask", 32'(iss_mask_o), 32'b01);
        tick();
        wb_valid_i = 2'b00;
        #1;
        chk("byp_setwins", dut.u_sb.busy_q, 32'h0000_0200);

        // Flush with lane1 stalled; a new packet goes in the following cycle
        clean();
        load(2'b11, mk(400, 5'd11, 5'd0, 5'd0), mk(401, 5'd12, 5'd11, 5'd0));
        tick();
        chk("fl_busy_pre", dut.u_sb.busy_q, 32'h0000_0800);
        flush_i = 1'b1;
        pkg_valid_i = 1'b1;
        pkg_mask_i = 2'b01;
        pkg_i[0] = mk(402, 5'd13, 5'd0, 5'd0);
        #1;
        chk("fl_ready_during", 32'(pkg_ready_o), 0);
        tick();
        flush_i = 1'b0;
        #1;
        chk("fl_iss_valid", 32'(iss_valid_o), 0);
        chk("fl_held", 32'(dut.held_valid_q), 0);
        chk("fl_busy", dut.u_sb.busy_q, 32'h0000_0800);
        chk("fl_ready", 32'(pkg_ready_o), 1);
        tick();
        pkg_valid_i = 1'b0;
        #1;
        chk("fl_new_mask", 32'(iss_mask_o), 32'b01);
        tick();

        // Asynchronous reset while stalled
        iss_ready_i = 1'b0;
        load(2'b11, mk(500, 5'd14, 5'd0, 5'd0), mk(501, 5'd15, 5'd0, 5'd0));
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_iss_valid", 32'(iss_valid_o), 0);
        chk("ar_pkg_ready", 32'(pkg_ready_o), 1);
        chk("ar_busy", dut.u_sb.busy_q, 0);
        chk("ar_perf", 32'(perf_stall_o), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        // Backend stall: stable offer, counted cycles, saturation
        load(2'b11, mk(600, 5'd16, 5'd0, 5'd0), mk(601, 5'd17, 5'd0, 5'd0));
        saved = iss_o;
        repeat (5) tick();
        chk("st_perf5", 32'(perf_stall_o), 5);
        chk("st_mask", 32'(iss_mask_o), 32'b11);
        checks++;
        if (iss_o !== saved) begin
            errors++;
            $display("FAIL st_iss_stable: got %0h expected %0h", iss_o, saved);
        end
        chk("st_busy", dut.u_sb.busy_q, 0);
        repeat (12) tick();
        chk("st_sat", 32'(perf_stall_o), 32'hF);
        iss_ready_i = 1'b1;
        #1;
        tick();
        chk("st_sat_hold", 32'(perf_stall_o), 32'hF);
        chk("st_busy_fire", dut.u_sb.busy_q, 32'h0003_0000);
        tick();
        chk("end_queue", 32'(expq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
